// File: rtl/countdown_ctrl.sv
// countdown_ctrl: mm:ss countdown sequencer (IDLE/RUN/PAUSE/DONE) with internal 1 Hz prescaler.
module countdown_ctrl #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MAX_MIN       = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [5:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_en,
  output logic       running,
  output logic       done
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);
  localparam logic [5:0] MAXM = 6'(MAX_MIN);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t        state_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    min_q, sec_q, ld_min, ld_sec, dec_min, dec_sec;
  logic          sec_en_q, running_q, done_q, tc, zero_q, dec_zero;
  assign ld_min   = preset_min > MAXM ? MAXM : preset_min;
  assign ld_sec   = preset_sec > 6'd59 ? 6'd59 : preset_sec;
  assign tc       = presc_q == TC;
  assign presc_d  = tc ? '0 : presc_q + 1'b1;
  assign zero_q   = min_q == 6'd0 && sec_q == 6'd0;
  // borrow from minutes only when seconds are exhausted; 00:00 never wraps
  assign dec_sec  = sec_q != 6'd0 ? sec_q - 6'd1 : (min_q != 6'd0 ? 6'd59 : 6'd0);
  assign dec_min  = sec_q == 6'd0 && min_q != 6'd0 ? min_q - 6'd1 : min_q;
  assign dec_zero = dec_min == 6'd0 && dec_sec == 6'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      sec_en_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sec_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            min_q <= ld_min;
            sec_q <= ld_sec;
          end else if (start && !zero_q) begin
            state_q   <= RUN;
            presc_q   <= '0;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          presc_q <= presc_d;
          if (tc) begin
            sec_en_q <= 1'b1;
            min_q    <= dec_min;
            sec_q    <= dec_sec;
          end
          // reaching 00:00 wins over a coincident pause
          if (tc && dec_zero) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (pause) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        DONE: begin
          if (load) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            min_q   <= ld_min;
            sec_q   <= ld_sec;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign min     = min_q;
  assign sec     = sec_q;
  assign sec_en  = sec_en_q;
  assign running = running_q;
  assign done    = done_q;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed scenarios plus randomized pulses against a seconds-remaining reference model.
module tb_countdown_ctrl;
  localparam int T = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  logic       clk = 1'b0;
  logic       reset = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [5:0] preset_min = '0, preset_sec = '0, min, sec;
  logic       sec_en, running, done;
  int         n_pass = 0, n_tot = 0;
  int         m_mode = M_IDLE, m_rem = 0, m_ph = 0;
  logic       m_en = 1'b0;
  always #5 clk = ~clk;
  countdown_ctrl #(.TICKS_PER_SEC(T), .MAX_MIN(59)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .pause(pause),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .min(min), .sec(sec), .sec_en(sec_en), .running(running), .done(done)
  );
  // model keeps total seconds remaining and a phase counter within the current second
  task automatic step(input logic r, input logic l, input logic s, input logic p, input int pm, input int ps);
    int ld;
    reset = r; load = l; start = s; pause = p;
    preset_min = 6'(pm); preset_sec = 6'(ps);
    ld = (pm > 59 ? 59 : pm) * 60 + (ps > 59 ? 59 : ps);
    m_en = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_rem = 0; m_ph = 0;
    end else if (m_mode == M_IDLE) begin
      if (l) m_rem = ld;
      else if (s && m_rem > 0) begin m_mode = M_RUN; m_ph = 0; end
    end else if (m_mode == M_RUN) begin
      if (m_ph == T - 1) begin m_en = 1'b1; m_rem = m_rem - 1; end
      m_ph = (m_ph + 1) % T;
      if (m_en && m_rem == 0) m_mode = M_DONE;
      else if (p) m_mode = M_PAUSE;
    end else if (m_mode == M_PAUSE) begin
      if (s) m_mode = M_RUN;
    end else if (l) begin
      m_mode = M_IDLE; m_rem = ld;
    end
    @(posedge clk); #1;
    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    step(1, 1, 1, 1, 33, 44);
    n_tot++;
    if ({min, sec, sec_en, running, done} !== 15'd0)
      $display("FAIL reset_state: got %0d:%0d en=%b run=%b done=%b exp all 0", min, sec, sec_en, running, done);
    else n_pass++;
  endtask
  task automatic test_full_countdown();
    int cyc, strobes;
    step(0, 1, 0, 0, 1, 2);
    n_tot++;
    if ({min, sec} !== {6'd1, 6'd2}) $display("FAIL load_0102: got %0d:%0d exp 1:2", min, sec);
    else n_pass++;
    step(0, 0, 1, 0, 0, 0);
    n_tot++;
    if ({running, min, sec} !== {1'b1, 6'd1, 6'd2}) $display("FAIL start_run: got run=%b %0d:%0d exp run=1 1:2", running, min, sec);
    else n_pass++;
    cyc = 0; strobes = 0;
    while (done !== 1'b1 && cyc < 400) begin
      idle(1);
      cyc++;
      n_tot++;
      if (sec_en !== (cyc % T == 0)) $display("FAIL strobe_phase: cycle %0d got en=%b exp %b", cyc, sec_en, cyc % T == 0);
      else n_pass++;
      if (sec_en === 1'b1) begin
        strobes++;
        n_tot++;
        if ({min, sec} !== {6'((62 - strobes) / 60), 6'((62 - strobes) % 60)})
          $display("FAIL count_seq: strobe %0d got %0d:%0d exp %0d:%0d", strobes, min, sec, (62 - strobes) / 60, (62 - strobes) % 60);
        else n_pass++;
      end
    end
    n_tot++;
    if (strobes !== 62 || cyc !== 248) $display("FAIL done_timing: got %0d strobes at cycle %0d exp 62 at 248", strobes, cyc);
    else n_pass++;
    n_tot++;
    if ({done, running, sec_en, min, sec} !== {3'b101, 12'd0}) $display("FAIL done_flags: got done=%b run=%b en=%b %0d:%0d exp 1 0 1 0:0", done, running, sec_en, min, sec);
    else n_pass++;
  endtask
  task automatic test_pause_resume();
    int bad;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 10);
    step(0, 0, 1, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 1, 0, 0);
    n_tot++;
    if ({running, min, sec} !== {1'b0, 6'd0, 6'd9}) $display("FAIL pause_enter: got run=%b %0d:%0d exp run=0 0:9", running, min, sec);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (sec_en !== 1'b0 || sec !== 6'd9) bad++;
    end
    n_tot++;
    if (bad != 0) $display("FAIL pause_frozen: got %0d bad cycles exp 0", bad);
    else n_pass++;
    step(0, 0, 1, 0, 0, 0);
    idle(1);
    n_tot++;
    if ({running, sec_en} !== 2'b10) $display("FAIL resume_early: got run=%b en=%b exp 1 0", running, sec_en);
    else n_pass++;
    idle(1);
    n_tot++;
    if ({sec_en, sec} !== {1'b1, 6'd8}) $display("FAIL resume_phase: got en=%b sec=%0d exp 1 8", sec_en, sec);
    else n_pass++;
  endtask
  task automatic test_clamp();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 63, 63);
    n_tot++;
    if ({min, sec} !== {6'd59, 6'd59}) $display("FAIL clamp_both: got %0d:%0d exp 59:59", min, sec);
    else n_pass++;
    step(0, 1, 0, 0, 61, 45);
    n_tot++;
    if ({min, sec} !== {6'd59, 6'd45}) $display("FAIL clamp_min: got %0d:%0d exp 59:45", min, sec);
    else n_pass++;
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(T);
    n_tot++;
    if ({running, done, sec_en, min, sec} !== 15'd0) $display("FAIL start_at_zero: got run=%b done=%b en=%b %0d:%0d exp all 0", running, done, sec_en, min, sec);
    else n_pass++;
  endtask
  task automatic test_priority();
    int cyc;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 5);
    n_tot++;
    if ({running, min, sec} !== {1'b0, 6'd0, 6'd5}) $display("FAIL load_over_start: got run=%b %0d:%0d exp run=0 0:5", running, min, sec);
    else n_pass++;
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 1, 0, 0);
    idle(T * 2);
    n_tot++;
    if ({running, done, min, sec} !== {2'b00, 6'd0, 6'd5}) $display("FAIL start_pause_run: got run=%b done=%b %0d:%0d exp 0 0 0:5", running, done, min, sec);
    else n_pass++;
    step(0, 1, 1, 0, 0, 0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin idle(1); cyc++; end
    n_tot++;
    if (done !== 1'b1) $display("FAIL reach_done: got done=%b exp 1 within 100 cycles", done);
    else n_pass++;
    step(0, 0, 1, 1, 0, 0);
    idle(T);
    n_tot++;
    if ({done, running, sec_en} !== 3'b100) $display("FAIL done_ignores_start: got done=%b run=%b en=%b exp 1 0 0", done, running, sec_en);
    else n_pass++;
    step(0, 1, 1, 0, 0, 7);
    n_tot++;
    if ({done, running, min, sec} !== {2'b00, 6'd0, 6'd7}) $display("FAIL done_load: got done=%b run=%b %0d:%0d exp 0 0 0:7", done, running, min, sec);
    else n_pass++;
  endtask
  task automatic test_reset_midrun();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 3);
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    n_tot++;
    if ({min, sec, sec_en, running, done} !== 15'd0) $display("FAIL reset_midrun: got %0d:%0d en=%b run=%b done=%b exp all 0", min, sec, sec_en, running, done);
    else n_pass++;
    idle(T * 2);
    n_tot++;
    if ({min, sec, sec_en, running, done} !== 15'd0) $display("FAIL reset_stays_idle: got %0d:%0d en=%b run=%b done=%b exp all 0", min, sec, sec_en, running, done);
    else n_pass++;
  endtask
  task automatic test_pause_final();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    idle(T - 1);
    step(0, 0, 0, 1, 0, 0);
    n_tot++;
    if ({done, running, sec_en, min, sec} !== {3'b101, 12'd0}) $display("FAIL pause_final: got done=%b run=%b en=%b %0d:%0d exp 1 0 1 0:0", done, running, sec_en, min, sec);
    else n_pass++;
    step(0, 0, 1, 0, 0, 0);
    n_tot++;
    if ({done, running} !== 2'b10) $display("FAIL not_paused: got done=%b run=%b exp 1 0", done, running);
    else n_pass++;
  endtask
  task automatic test_random();
    int bad, pm;
    logic [14:0] exp_v;
    step(1, 0, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      pm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : 0;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, pm, int'($urandom_range(0, 63)));
      exp_v = {6'(m_rem / 60), 6'(m_rem % 60), m_en, m_mode == M_RUN, m_mode == M_DONE};
      n_tot++;
      if ({min, sec, sec_en, running, done} !== exp_v) begin
        if (bad < 10)
          $display("FAIL random_cycle %0d: got %0d:%0d en=%b run=%b done=%b exp %0d:%0d en=%b run=%b done=%b",
                   i, min, sec, sec_en, running, done, exp_v[14:9], exp_v[8:3], exp_v[2], exp_v[1], exp_v[0]);
        bad++;
      end else n_pass++;
    end
  endtask
  initial begin
    test_reset();
    test_full_countdown();
    test_pause_resume();
    test_clamp();
    test_priority();
    test_reset_midrun();
    test_pause_final();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
